ws2812_decoder: RTL and testbench

WS2812_DECODER -- requirements
Module: ws2812_decoder

---
 rtl/ws2812_decoder.sv | 227 ++++++++++++++++++++++
 tb/tb_ws2812_decoder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_decoder.sv
// ws2812_decoder
// ---------------------------------------------------------------------------
// Recovers 24-bit pixel words from a WS2812-style one-wire NRZ LED stream.
// Each bit is a high pulse whose width selects 0 or 1, followed by a low
// time. A long low gap (the latch gap) ends the frame.
//
// Ports
//   clk          24 MHz clock, every flop on its rising edge
//   reset        synchronous, active-high reset
//   din          asynchronous serial LED data input
//   rgb          last completed pixel word, first-received bit in bit 23
//   rgb_valid    one-cycle strobe when rgb updates
//   frame_end    one-cycle strobe when the latch gap is detected
//   pixel_count  pixels completed in the current frame (saturates at 255)
//   bit_err      one-cycle strobe on any width or framing error
//
// Width measurement
//   The width counter is cleared on the edge that enters HIGH or LOW and then
//   counts cycles spent in that state. The measured width w used for every
//   decision is the counter plus the cycle being observed, so a synchronized
//   high pulse of N cycles is classified with w = N.
// ---------------------------------------------------------------------------
module ws2812_decoder #(
    parameter int T_BIT1  = 14,
    parameter int T_MIN   = 4,
    parameter int T_MAX   = 40,
    parameter int T_LATCH = 1200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        din,
    output logic [23:0] rgb,
    output logic        rgb_valid,
    output logic        frame_end,
    output logic [7:0]  pixel_count,
    output logic        bit_err
);

    // Thresholds brought to the counter width once, so compares stay 11-bit.
    localparam logic [10:0] T_BIT1_W   = 11'(T_BIT1);
    localparam logic [10:0] T_MIN_W    = 11'(T_MIN);
    localparam logic [10:0] T_MAX_W    = 11'(T_MAX);
    localparam logic [10:0] T_TIMEOUT  = 11'(T_MAX + 1);
    localparam logic [10:0] T_LATCH_W  = 11'(T_LATCH);
    localparam logic [10:0] CNT_MAX    = 11'h7FF;
    localparam logic [4:0]  WORD_BITS  = 5'd24;
    localparam logic [7:0]  PIX_MAX    = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        ERR
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        din_s1;
    logic        din_s2;
    logic        din_prev;
    logic        rise;
    logic        fall;

    logic [10:0] cnt;
    logic [10:0] cnt_next;
    logic [10:0] cnt_inc;

    logic [23:0] shreg;
    logic [4:0]  bit_cnt;
    logic        word_done;

    logic        shift_en;
    logic        shift_val;
    logic        word_clear;
    logic        err_evt;
    logic        latch_evt;

    // Edges come only from the synchronized copy; din_prev is the history flop.
    assign rise = din_s2 & ~din_prev;
    assign fall = ~din_s2 & din_prev;

    // Saturating increment: the counter sticks at its maximum instead of
    // wrapping, so a stuck line can never look like a fresh short pulse.
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 11'd1;

    // Bit counter reaches 24 for exactly one cycle after the last shift; that
    // cycle transfers the word to rgb.
    assign word_done = (bit_cnt == WORD_BITS);

    // Next-state and event logic. Latch detection in LOW is tested before the
    // rising edge so a coincident edge loses to the end-of-frame decision.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        shift_en   = 1'b0;
        shift_val  = 1'b0;
        word_clear = 1'b0;
        err_evt    = 1'b0;
        latch_evt  = 1'b0;

        case (state)
            IDLE: begin
                if (rise) begin
                    state_next = HIGH;
                    cnt_next   = '0;
                end
            end

            HIGH: begin
                if (fall) begin
                    if ((cnt_inc < T_MIN_W) || (cnt_inc > T_MAX_W)) begin
                        err_evt    = 1'b1;
                        word_clear = 1'b1;
                        state_next = ERR;
                        cnt_next   = '0;
                    end else begin
                        shift_en   = 1'b1;
                        shift_val  = (cnt_inc >= T_BIT1_W);
                        state_next = LOW;
                        cnt_next   = '0;
                    end
                end else if (cnt_inc >= T_TIMEOUT) begin
                    // Pulse already too long; give up without waiting for the fall.
                    err_evt    = 1'b1;
                    word_clear = 1'b1;
                    state_next = ERR;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end

            LOW: begin
                if (cnt_inc >= T_LATCH_W) begin
                    latch_evt  = 1'b1;
                    err_evt    = (bit_cnt != 5'd0);
                    word_clear = 1'b1;
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (rise) begin
                    state_next = HIGH;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end

            ERR: begin
                // Only an unbroken low stretch of latch length recovers.
                if (din_s2) begin
                    cnt_next = '0;
                end else if (cnt_inc >= T_LATCH_W) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // State register, synchronizer and registered strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            din_s1    <= 1'b0;
            din_s2    <= 1'b0;
            din_prev  <= 1'b0;
            bit_err   <= 1'b0;
            frame_end <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            din_s1    <= din;
            din_s2    <= din_s1;
            din_prev  <= din_s2;
            bit_err   <= err_evt;
            frame_end <= latch_evt;
        end
    end

    // Word assembly. A clear (error entry or latch with a partial word)
    // discards the shift register and leaves rgb untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            rgb       <= '0;
            rgb_valid <= 1'b0;
        end else begin
            rgb_valid <= 1'b0;
            if (word_clear) begin
                shreg   <= '0;
                bit_cnt <= '0;
            end else if (shift_en) begin
                shreg   <= {shreg[22:0], shift_val};
                bit_cnt <= bit_cnt + 5'd1;
            end else if (word_done) begin
                rgb       <= shreg;
                rgb_valid <= 1'b1;
                bit_cnt   <= '0;
            end
        end
    end

    // Pixel counter: counts completed words, cleared the cycle after
    // frame_end, otherwise held (including through ERR).
    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_count <= '0;
        end else if (frame_end) begin
            pixel_count <= '0;
        end else if (word_done && !word_clear && !shift_en) begin
            if (pixel_count != PIX_MAX) begin
                pixel_count <= pixel_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ws2812_decoder.sv
// tb_ws2812_decoder
// ---------------------------------------------------------------------------
// Self-checking bench for ws2812_decoder. Words are driven bit by bit with
// T0H = 10, T1H = 19 and a 30-cycle bit period. Every full word driven is
// pushed to a scoreboard queue; a negedge monitor pops and compares on each
// rgb_valid and keeps strobe counts the scenarios check afterwards.
// ---------------------------------------------------------------------------
module tb_ws2812_decoder;

    localparam int T_BIT1  = 14;
    localparam int T_MIN   = 4;
    localparam int T_MAX   = 40;
    localparam int T_LATCH = 1200;
    localparam int T0H     = 10;
    localparam int T1H     = 19;
    localparam int TBIT    = 30;
    localparam int GAP     = T_LATCH + 20;

    logic        clk;
    logic        reset;
    logic        din;
    logic [23:0] rgb;
    logic        rgb_valid;
    logic        frame_end;
    logic [7:0]  pixel_count;
    logic        bit_err;

    int          total;
    int          bad;
    int          cyc;
    int          fall_cyc;

    logic [23:0] exp_q[$];

    int          valid_cnt;
    int          fe_cnt;
    int          err_cnt;
    int          fe_pix;
    int          fe_pix_after;
    int          fe_err;
    logic        prev_valid;
    logic        prev_fe;
    logic        prev_err;

    ws2812_decoder #(
        .T_BIT1 (T_BIT1),
        .T_MIN  (T_MIN),
        .T_MAX  (T_MAX),
        .T_LATCH(T_LATCH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .rgb        (rgb),
        .rgb_valid  (rgb_valid),
        .frame_end  (frame_end),
        .pixel_count(pixel_count),
        .bit_err    (bit_err)
    );

    // Free-running clock and a cycle counter used for latency checks.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // One comparison: counts it and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total = total + 1;
        if (got !== want) begin
            bad = bad + 1;
            $display("[TB] FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Drives one bit: high for T0H/T1H cycles, then low to the bit period.
    // Inputs change on the falling clock edge, away from the sampling edge.
    task automatic driveBit(input logic b);
        din = 1'b1;
        repeat (b ? T1H : T0H) @(negedge clk);
        din = 1'b0;
        fall_cyc = cyc;
        repeat (b ? (TBIT - T1H) : (TBIT - T0H)) @(negedge clk);
    endtask

    // Drives the top nbits of word, MSB first.
    task automatic driveBits(input logic [23:0] word, input int nbits);
        for (int i = 23; i > 23 - nbits; i--) begin
            driveBit(word[i]);
        end
    endtask

    // Drives a full word and records the value the DUT must report.
    task automatic applyStimulus(input logic [23:0] word);
        exp_q.push_back(word);
        driveBits(word, 24);
    endtask

    task automatic lowGap(input int n);
        din = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Monitor: scoreboard pop on rgb_valid, 4-cycle latency from the raw
    // falling edge of bit 24, single-cycle strobes, and frame_end snapshots.
    always @(negedge clk) begin
        if (rgb_valid) begin
            valid_cnt = valid_cnt + 1;
            checkOutput("valid_single", {31'd0, prev_valid}, 32'd0);
            checkOutput("latency", cyc - fall_cyc, 32'd4);
            checkOutput("sb_nonempty", {31'd0, (exp_q.size() != 0)}, 32'd1);
            if (exp_q.size() != 0) begin
                checkOutput("rgb", {8'd0, rgb}, {8'd0, exp_q.pop_front()});
            end
        end
        if (frame_end) begin
            fe_cnt = fe_cnt + 1;
            checkOutput("fe_single", {31'd0, prev_fe}, 32'd0);
            fe_pix = int'(pixel_count);
            fe_err = int'(bit_err);
        end
        if (prev_fe) begin
            fe_pix_after = int'(pixel_count);
        end
        if (bit_err) begin
            err_cnt = err_cnt + 1;
            checkOutput("err_single", {31'd0, prev_err}, 32'd0);
        end
        prev_valid = rgb_valid;
        prev_fe    = frame_end;
        prev_err   = bit_err;
    end

    // Main sequence of scenarios.
    initial begin
        int v0;
        int f0;
        int e0;
        int rise_cyc;
        int err_at;

        total = 0; bad = 0; cyc = 0; fall_cyc = 0;
        valid_cnt = 0; fe_cnt = 0; err_cnt = 0;
        fe_pix = -1; fe_pix_after = -1; fe_err = -1;
        prev_valid = 1'b0; prev_fe = 1'b0; prev_err = 1'b0;
        din = 1'b0;
        reset = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_rgb", {8'd0, rgb}, 32'd0);
        checkOutput("rst_valid", {31'd0, rgb_valid}, 32'd0);
        checkOutput("rst_fe", {31'd0, frame_end}, 32'd0);
        checkOutput("rst_pix", {24'd0, pixel_count}, 32'd0);
        checkOutput("rst_err", {31'd0, bit_err}, 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Single word then latch gap
        v0 = valid_cnt; f0 = fe_cnt; e0 = err_cnt;
        applyStimulus(24'h00CEFF);
        lowGap(GAP);
        checkOutput("s1_valids", valid_cnt - v0, 32'd1);
        checkOutput("s1_fe", fe_cnt - f0, 32'd1);
        checkOutput("s1_errs", err_cnt - e0, 32'd0);
        checkOutput("s1_pix_at_fe", fe_pix, 32'd1);
        checkOutput("s1_pix_after", fe_pix_after, 32'd0);
        checkOutput("s1_rgb_hold", {8'd0, rgb}, 32'h00CEFF);

        // Six pixels back to back
        v0 = valid_cnt; f0 = fe_cnt;
        for (int p = 0; p < 6; p++) begin
            applyStimulus((p < 3) ? 24'h00CEFF : 24'h7F32A8);
        end
        lowGap(GAP);
        checkOutput("s2_valids", valid_cnt - v0, 32'd6);
        checkOutput("s2_fe", fe_cnt - f0, 32'd1);
        checkOutput("s2_pix_at_fe", fe_pix, 32'd6);
        checkOutput("s2_pix_after", fe_pix_after, 32'd0);
        checkOutput("s2_sb_drained", exp_q.size(), 32'd0);

        // Glitch mid-word, then a clean frame
        v0 = valid_cnt; f0 = fe_cnt; e0 = err_cnt;
        driveBits(24'hA5A5A5, 5);
        din = 1'b1;
        repeat (2) @(negedge clk);
        lowGap(TBIT - 2);
        driveBits(24'h3C3C3C, 10);
        lowGap(GAP);
        checkOutput("s3_errs", err_cnt - e0, 32'd1);
        checkOutput("s3_valids", valid_cnt - v0, 32'd0);
        checkOutput("s3_fe", fe_cnt - f0, 32'd0);
        v0 = valid_cnt; f0 = fe_cnt;
        applyStimulus(24'h7F32A8);
        lowGap(GAP);
        checkOutput("s3_clean_valids", valid_cnt - v0, 32'd1);
        checkOutput("s3_clean_fe", fe_cnt - f0, 32'd1);

        // Partial word at latch time: frame_end with bit_err, rgb unchanged
        v0 = valid_cnt; f0 = fe_cnt; e0 = err_cnt;
        driveBits(24'hABCDEF, 12);
        lowGap(GAP);
        checkOutput("s4_fe", fe_cnt - f0, 32'd1);
        checkOutput("s4_err_with_fe", fe_err, 32'd1);
        checkOutput("s4_errs", err_cnt - e0, 32'd1);
        checkOutput("s4_valids", valid_cnt - v0, 32'd0);
        checkOutput("s4_rgb_kept", {8'd0, rgb}, 32'h7F32A8);

        // Over-long high pulse: error after the synchronizer (2 cycles),
        // T_MAX+1 counted high cycles plus the deciding cycle, and the
        // output register -> T_MAX+4 cycles from the raw rising edge.
        v0 = valid_cnt; f0 = fe_cnt; e0 = err_cnt;
        err_at = 0;
        rise_cyc = cyc;
        din = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bit_err && err_at == 0) err_at = cyc - rise_cyc;
        end
        checkOutput("s5_timeout_at", err_at, T_MAX + 4);
        lowGap(600);
        driveBits(24'h123456, 24);
        lowGap(GAP);
        checkOutput("s5_ignored_valids", valid_cnt - v0, 32'd0);
        checkOutput("s5_no_fe", fe_cnt - f0, 32'd0);
        checkOutput("s5_errs", err_cnt - e0, 32'd1);
        v0 = valid_cnt;
        applyStimulus(24'h00CEFF);
        lowGap(GAP);
        checkOutput("s5_clean_valids", valid_cnt - v0, 32'd1);

        // Reset at bit 17, then a full word
        v0 = valid_cnt; f0 = fe_cnt; e0 = err_cnt;
        driveBits(24'hFFFFFF, 17);
        reset = 1'b1;
        din = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("s6_rst_rgb", {8'd0, rgb}, 32'd0);
        checkOutput("s6_rst_pix", {24'd0, pixel_count}, 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("s6_no_strobes", (valid_cnt - v0) + (fe_cnt - f0) + (err_cnt - e0), 32'd0);
        v0 = valid_cnt;
        applyStimulus(24'h7F32A8);
        lowGap(GAP);
        checkOutput("s6_valids", valid_cnt - v0, 32'd1);
        checkOutput("s6_rgb", {8'd0, rgb}, 32'h7F32A8);
        checkOutput("final_sb_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
